// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the fetch-to-decode instruction buffer.
//   XLEN         width of PC and instruction words
//   NOP_INS      instruction presented to decode while the buffer is empty
//   PC_RESET_VEC PC the fetch stage starts from after reset
//   entry_t      one buffered {PC, instruction} pair
package if_id_buffer_pkg;

    localparam int unsigned     XLEN         = 32;
    localparam logic [XLEN-1:0] NOP_INS      = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_RESET_VEC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

endpackage

// File: rtl/if_id_if.sv
// Fetch/decode-side bundle of the IF/ID buffer.
//   master : fetch + control side (drives In_*, Flush, Hold)
//   slave  : the buffer (drives In_Ready, Out_*, Occupancy)
interface if_id_if #(
    parameter int unsigned Depth = 2
) ();
    import if_id_buffer_pkg::*;

    logic                         In_Valid;
    logic [XLEN-1:0]              In_PC;
    logic [XLEN-1:0]              In_Instr;
    logic                         In_Ready;
    logic                         Flush;
    logic                         Hold;
    logic                         Out_Valid;
    logic [XLEN-1:0]              Out_PC;
    logic [XLEN-1:0]              Out_Instr;
    logic [$clog2(Depth+1)-1:0]   Occupancy;

    modport master (
        output In_Valid, In_PC, In_Instr, Flush, Hold,
        input  In_Ready, Out_Valid, Out_PC, Out_Instr, Occupancy
    );

    modport slave (
        input  In_Valid, In_PC, In_Instr, Flush, Hold,
        output In_Ready, Out_Valid, Out_PC, Out_Instr, Occupancy
    );

endinterface

// File: rtl/if_id_mem.sv
// Storage array for the IF/ID buffer: DEPTH entries of {PC, instr}.
// One synchronous write port, one asynchronous read port, no reset
// (validity is tracked entirely by the pointers/count in the parent).
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write index
//   wr_data_i  entry to store
//   rd_addr_i  read index
//   rd_data_o  entry at rd_addr_i
module if_id_mem
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  entry_t                   wr_data_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output entry_t                   rd_data_o
);

    entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/if_id_buffer.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO of
// {PC, instruction} pairs. In_Ready doubles as the PC write-enable.
//   Clk   clock, rising edge
//   Rst   asynchronous active-low reset
//   bus   if_id_if slave: In_Valid/In_PC/In_Instr/In_Ready from fetch,
//         Flush/Hold from control, Out_Valid/Out_PC/Out_Instr/Occupancy to decode
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    Clk,
    input  logic    Rst,
    if_id_if.slave  bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic   in_ready;
    logic   out_valid;
    logic   push;
    logic   pop;
    entry_t wr_entry;
    entry_t rd_entry;

    // Both flags come from state only, so Hold/Flush never reach In_Ready combinationally.
    assign in_ready  = (count_q != CntW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign push = bus.In_Valid & in_ready & ~bus.Flush;
    assign pop  = out_valid & ~bus.Hold & ~bus.Flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so wrap is implicit.
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_entry.pc    = bus.In_PC;
    assign wr_entry.instr = bus.In_Instr;

    if_id_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk_i     (Clk),
        .wr_en_i   (push),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_entry),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_entry)
    );

    assign bus.In_Ready  = in_ready;
    assign bus.Out_Valid = out_valid;
    assign bus.Out_PC    = out_valid ? rd_entry.pc    : '0;
    assign bus.Out_Instr = out_valid ? rd_entry.instr : NOP_INS;
    assign bus.Occupancy = count_q;

endmodule

// File: tb/tb_if_id_buffer.sv
module tb_if_id_buffer;
    import if_id_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    always #5 clk = ~clk;

    if_id_if #(.Depth(2)) bus2 ();
    if_id_if #(.Depth(4)) bus4 ();

    if_id_buffer #(.DEPTH(2)) u_dut2 (.Clk(clk), .Rst(rst_n), .bus(bus2));
    if_id_buffer #(.DEPTH(4)) u_dut4 (.Clk(clk), .Rst(rst_n), .bus(bus4));

    // Same stimulus to both instances; only the wrap test checks the DEPTH=4 one.
    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic hold, input logic flush);
        bus2.In_Valid = v; bus2.In_PC = pc; bus2.In_Instr = ins;
        bus2.Hold = hold;  bus2.Flush = flush;
        bus4.In_Valid = v; bus4.In_PC = pc; bus4.In_Instr = ins;
        bus4.Hold = hold;  bus4.Flush = flush;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) tick();
        vectors++; if (bus2.Out_Valid !== 1'b0) begin miscompares++;
            $display("FAIL rst_valid: got %b want 0", bus2.Out_Valid); end
        vectors++; if (bus2.Out_Instr !== 32'h0000_0013) begin miscompares++;
            $display("FAIL rst_instr: got %h want 00000013", bus2.Out_Instr); end
        vectors++; if (bus2.In_Ready !== 1'b1) begin miscompares++;
            $display("FAIL rst_ready: got %b want 1", bus2.In_Ready); end
        rst_n = 1'b1;
        drv(1'b1, 32'h200, 32'hDDDD_0001, 1'b1, 1'b0); tick();
        drv(1'b1, 32'h204, 32'hDDDD_0002, 1'b1, 1'b0); tick();
        drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        vectors++; if (bus2.Occupancy !== 2'd2) begin miscompares++;
            $display("FAIL rst_prefill_occ: got %0d want 2", bus2.Occupancy); end
        // Assert reset mid-cycle, away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (bus2.Out_Valid !== 1'b0) begin miscompares++;
            $display("FAIL rst_async_valid: got %b want 0", bus2.Out_Valid); end
        vectors++; if (bus2.Out_Instr !== 32'h0000_0013) begin miscompares++;
            $display("FAIL rst_async_instr: got %h want 00000013", bus2.Out_Instr); end
        vectors++; if (bus2.Out_PC !== 32'h0) begin miscompares++;
            $display("FAIL rst_async_pc: got %h want 0", bus2.Out_PC); end
        vectors++; if (bus2.Occupancy !== 2'd0) begin miscompares++;
            $display("FAIL rst_async_occ: got %0d want 0", bus2.Occupancy); end
        vectors++; if (bus2.In_Ready !== 1'b1) begin miscompares++;
            $display("FAIL rst_async_ready: got %b want 1", bus2.In_Ready); end
        #1 rst_n = 1'b1;
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_streaming;
        logic [31:0] pc;
        logic [31:0] ins;
        for (int k = 0; k < 3; k++) begin
            pc  = PC_RESET_VEC + 32'(4 * k);
            ins = 32'hAAAA_0001 + 32'(k);
            drv(1'b1, pc, ins, 1'b0, 1'b0);
            if (k == 0) begin
                #1;
                vectors++; if (bus2.Out_Valid !== 1'b0) begin miscompares++;
                    $display("FAIL stream_no_writethrough: got %b want 0", bus2.Out_Valid); end
            end
            tick();
            vectors++; if (bus2.Out_PC !== pc) begin miscompares++;
                $display("FAIL stream_pc%0d: got %h want %h", k, bus2.Out_PC, pc); end
            vectors++; if (bus2.Out_Instr !== ins) begin miscompares++;
                $display("FAIL stream_instr%0d: got %h want %h", k, bus2.Out_Instr, ins); end
            vectors++; if (bus2.Occupancy !== 2'd1) begin miscompares++;
                $display("FAIL stream_occ%0d: got %0d want 1", k, bus2.Occupancy); end
        end
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
        vectors++; if (bus2.Out_Valid !== 1'b0 || bus2.Out_PC !== 32'h0) begin miscompares++;
            $display("FAIL stream_drain: got valid=%b pc=%h want 0/0",
                     bus2.Out_Valid, bus2.Out_PC); end
    endtask

    task automatic test_fill;
        drv(1'b1, 32'h10, 32'hBBBB_0010, 1'b1, 1'b0); tick();
        vectors++; if (bus2.Occupancy !== 2'd1 || bus2.In_Ready !== 1'b1) begin miscompares++;
            $display("FAIL fill_1: got occ=%0d rdy=%b want 1/1", bus2.Occupancy, bus2.In_Ready); end
        drv(1'b1, 32'h14, 32'hBBBB_0014, 1'b1, 1'b0); tick();
        vectors++; if (bus2.Occupancy !== 2'd2 || bus2.In_Ready !== 1'b0) begin miscompares++;
            $display("FAIL fill_2: got occ=%0d rdy=%b want 2/0", bus2.Occupancy, bus2.In_Ready); end
        drv(1'b1, 32'h18, 32'hBBBB_0018, 1'b1, 1'b0); tick();
        vectors++; if (bus2.Occupancy !== 2'd2 || bus2.Out_PC !== 32'h10) begin miscompares++;
            $display("FAIL fill_ignored: got occ=%0d pc=%h want 2/10",
                     bus2.Occupancy, bus2.Out_PC); end
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
        vectors++; if (bus2.Out_PC !== 32'h14 || bus2.Out_Instr !== 32'hBBBB_0014) begin
            miscompares++;
            $display("FAIL fill_pop1: got %h/%h want 14/bbbb0014", bus2.Out_PC, bus2.Out_Instr); end
        vectors++; if (bus2.In_Ready !== 1'b1 || bus2.Occupancy !== 2'd1) begin miscompares++;
            $display("FAIL fill_pop1_rdy: got rdy=%b occ=%0d want 1/1",
                     bus2.In_Ready, bus2.Occupancy); end
        tick();
        vectors++; if (bus2.Out_Valid !== 1'b0 || bus2.Occupancy !== 2'd0) begin miscompares++;
            $display("FAIL fill_empty: got valid=%b occ=%0d want 0/0",
                     bus2.Out_Valid, bus2.Occupancy); end
    endtask

    task automatic test_full_push_pop;
        drv(1'b1, 32'h20, 32'hEEEE_0020, 1'b1, 1'b0); tick();
        drv(1'b1, 32'h24, 32'hEEEE_0024, 1'b1, 1'b0); tick();
        drv(1'b1, 32'h28, 32'hEEEE_0028, 1'b0, 1'b0);
        #1;
        vectors++; if (bus2.In_Ready !== 1'b0) begin miscompares++;
            $display("FAIL full_pp_ready_pre: got %b want 0", bus2.In_Ready); end
        tick();
        vectors++; if (bus2.Occupancy !== 2'd1 || bus2.Out_PC !== 32'h24) begin miscompares++;
            $display("FAIL full_pp_after: got occ=%0d pc=%h want 1/24",
                     bus2.Occupancy, bus2.Out_PC); end
        vectors++; if (bus2.In_Ready !== 1'b1) begin miscompares++;
            $display("FAIL full_pp_ready_post: got %b want 1", bus2.In_Ready); end
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
        vectors++; if (bus2.Out_Valid !== 1'b0 || bus2.Occupancy !== 2'd0) begin miscompares++;
            $display("FAIL full_pp_rejected: got valid=%b occ=%0d want 0/0",
                     bus2.Out_Valid, bus2.Occupancy); end
    endtask

    task automatic test_flush;
        drv(1'b1, 32'h30, 32'hF000_0030, 1'b1, 1'b0); tick();
        drv(1'b1, 32'h34, 32'hF000_0034, 1'b1, 1'b0); tick();
        drv(1'b1, 32'h40, 32'hF000_0040, 1'b1, 1'b1); tick();
        vectors++; if (bus2.Out_Valid !== 1'b0 || bus2.Occupancy !== 2'd0) begin miscompares++;
            $display("FAIL flush_full: got valid=%b occ=%0d want 0/0",
                     bus2.Out_Valid, bus2.Occupancy); end
        vectors++; if (bus2.In_Ready !== 1'b1 || bus2.Out_Instr !== 32'h0000_0013) begin
            miscompares++;
            $display("FAIL flush_full_out: got rdy=%b instr=%h want 1/00000013",
                     bus2.In_Ready, bus2.Out_Instr); end
        // Partial buffer: a push and pop that would both fire are overridden.
        drv(1'b1, 32'h50, 32'hF000_0050, 1'b1, 1'b0); tick();
        drv(1'b1, 32'h44, 32'hF000_0044, 1'b0, 1'b1); tick();
        vectors++; if (bus2.Out_Valid !== 1'b0 || bus2.Occupancy !== 2'd0) begin miscompares++;
            $display("FAIL flush_partial: got valid=%b occ=%0d want 0/0",
                     bus2.Out_Valid, bus2.Occupancy); end
        drv(1'b1, 32'h80, 32'hF000_0080, 1'b0, 1'b0); tick();
        vectors++; if (bus2.Out_PC !== 32'h80 || bus2.Occupancy !== 2'd1) begin miscompares++;
            $display("FAIL flush_next_push: got pc=%h occ=%0d want 80/1",
                     bus2.Out_PC, bus2.Occupancy); end
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    endtask

    task automatic test_wrap;
        logic [63:0] q2[$];
        logic [63:0] q4[$];
        logic        v, hold, p2, o2, p4, o4;
        logic [31:0] pc, ins;
        logic [0:0]  d2;
        logic [1:0]  d4;
        // Clear both instances first.
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); tick();
        for (int i = 0; i < 18; i++) begin
            v    = (i < 12) && (i != 5);
            hold = (i < 12) && (i % 3 == 0);
            pc   = 32'h100 + 32'(4 * i);
            ins  = 32'hCC00_0000 | 32'(i);
            drv(v, pc, ins, hold, 1'b0);
            #1;
            vectors++; if (bus2.Occupancy !== 2'(q2.size())) begin miscompares++;
                $display("FAIL wrap2_occ%0d: got %0d want %0d", i, bus2.Occupancy, q2.size()); end
            vectors++; if (bus4.Occupancy !== 3'(q4.size())) begin miscompares++;
                $display("FAIL wrap4_occ%0d: got %0d want %0d", i, bus4.Occupancy, q4.size()); end
            if (q2.size() != 0) begin
                vectors++; if ({bus2.Out_PC, bus2.Out_Instr} !== q2[0]) begin miscompares++;
                    $display("FAIL wrap2_head%0d: got %h want %h", i,
                             {bus2.Out_PC, bus2.Out_Instr}, q2[0]); end
            end
            if (q4.size() != 0) begin
                vectors++; if ({bus4.Out_PC, bus4.Out_Instr} !== q4[0]) begin miscompares++;
                    $display("FAIL wrap4_head%0d: got %h want %h", i,
                             {bus4.Out_PC, bus4.Out_Instr}, q4[0]); end
            end
            d2 = u_dut2.wr_ptr_q - u_dut2.rd_ptr_q;
            d4 = u_dut4.wr_ptr_q - u_dut4.rd_ptr_q;
            vectors++; if (d2 !== 1'(q2.size() % 2) || d4 !== 2'(q4.size() % 4)) begin
                miscompares++;
                $display("FAIL wrap_ptr%0d: got %0d/%0d want %0d/%0d", i, d2, d4,
                         q2.size() % 2, q4.size() % 4); end
            p2 = v && (q2.size() != 2);
            o2 = (q2.size() != 0) && !hold;
            p4 = v && (q4.size() != 4);
            o4 = (q4.size() != 0) && !hold;
            if (o2) void'(q2.pop_front());
            if (p2) q2.push_back({pc, ins});
            if (o4) void'(q4.pop_front());
            if (p4) q4.push_back({pc, ins});
            tick();
        end
        vectors++; if (bus2.Out_Valid !== 1'b0 || bus4.Out_Valid !== 1'b0) begin miscompares++;
            $display("FAIL wrap_drained: got %b/%b want 0/0", bus2.Out_Valid, bus4.Out_Valid); end
    endtask

    initial begin
        drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_fill();
        test_full_push_pop();
        test_flush();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
